pc_stack_unit: RTL and testbench
================================

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 Parameter PC_W, default 12, program counter and return-address width in bits.
REQ-002 Parameter DEPTH, default 8, return-stack entries; power of two, 2 to 16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 hold  input  1  stall; 1 freezes PC, stack, pointer and flags.
REQ-006 pc_state  input  2  next-PC select from controller: 00 inc, 01 return, 10 jump, 11 branch.
REQ-007 push  input  1  JSB: push return address PC+1.
REQ-008 pop  input  1  RET: remove top entry.
REQ-009 jmp_target  input  PC_W  absolute target for pc_state 10.
REQ-010 br_offset  input  8  two's-complement offset for pc_state 11.
REQ-011 pc  output  PC_W  current program counter.
REQ-012 top  output  PC_W  top stack entry; 0 when empty.
REQ-013 count  output  $clog2(DEPTH)+1  valid entries, 0..DEPTH.
REQ-014 empty, full  output  1 each  count==0 / count==DEPTH, combinational from count.
REQ-015 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Next PC on a non-hold cycle SHALL be: 00 -> pc+1; 10 -> jmp_target; 11 -> pc+1+sign_extend(br_offset); 01 -> top if not empty, else pc+1.
REQ-017 All PC arithmetic SHALL be modulo 2^PC_W (wrap, no saturation).
REQ-018 pc_state 01 SHALL take the return address from top regardless of pop; stack removal occurs only when pop=1.
REQ-019 push alone, not full: write pc+1 (current pc) at index count, count+1, same edge as PC update.
REQ-020 push alone, full: no write, count unchanged, overflow set; PC still updates per pc_state.
REQ-021 pop alone, not empty: count-1; entry contents not cleared.
REQ-022 pop alone, empty: count stays 0, underflow set.
REQ-023 push and pop together, not empty: top entry overwritten with pc+1, count unchanged.
REQ-024 push and pop together, empty: treated as push alone; underflow not set.
REQ-025 hold=1 SHALL override push, pop and pc_state; no state changes, outputs stable.
REQ-026 top, empty, full SHALL reflect registered state only (no input-to-output combinational path).
REQ-027 Latency: every effect visible on outputs exactly one clock after the sampling edge.
REQ-028 overflow and underflow SHALL remain set until reset; they do not block further operation.

Reset
REQ-029 rst=1 at a rising edge SHALL set pc=0, count=0, overflow=0, underflow=0; top reads 0.
REQ-030 Stack storage contents SHALL be left unchanged by reset.
REQ-031 rst SHALL take priority over hold, push, pop and pc_state in the same cycle.
REQ-032 Reset mid-call-chain SHALL discard all entries; a later pc_state 01 with pop yields pc+1 and sets underflow.

Verification
REQ-033 Reset, then 5 cycles pc_state=00 -> pc=5, count=0, empty=1.
REQ-034 pc=0x010, pc_state=10, jmp_target=0x200, push=1 -> pc=0x200, top=0x011, count=1; then pc_state=01, pop=1 -> pc=0x011, count=0.
REQ-035 pc=0x005, pc_state=11, br_offset=0xFA (-6) -> pc=0x000; pc=0xFFF, pc_state=00 -> pc=0x000.
REQ-036 9 consecutive JSBs with DEPTH=8 -> count=8, full=1, overflow=1 after 9th, top = return address of 8th JSB; 8 RETs return in LIFO order, 9th RET sets underflow, pc advances by 1.
REQ-037 hold=1 with push=1, pc_state=10 for 3 cycles -> pc, count, top unchanged; release -> single push and jump occur.
REQ-038 count=3, push=1 and pop=1 at pc=0x040 -> count=3, top=0x041; rst=1 with push=1 same cycle -> pc=0, count=0.

Source files
------------

// File: rtl/pc_stack_unit.sv
// Program counter with a hardware return-address stack (JSB/RET support).
// Latency: every state change is visible on the outputs one clock after the sampling edge.
// Backpressure: none is generated; hold=1 freezes PC, stack, pointer and error flags.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   hold                stall; overrides pc_state, push and pop
//   pc_state[1:0]       next-PC select: 00 inc, 01 return, 10 jump, 11 branch
//   push / pop          JSB (push PC+1) / RET (drop top entry)
//   jmp_target[PC_W]    absolute jump target
//   br_offset[8]        two's-complement branch offset, relative to PC+1
//   pc, top             current PC and top-of-stack (0 when empty)
//   count               valid entries 0..DEPTH
//   empty, full         decoded from count
//   overflow, underflow sticky error flags, cleared only by reset
module pc_stack_unit #(
  parameter int PC_W  = 12,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic [1:0]             pc_state,
  input  logic                   push,
  input  logic                   pop,
  input  logic [PC_W-1:0]        jmp_target,
  input  logic [7:0]             br_offset,
  output logic [PC_W-1:0]        pc,
  output logic [PC_W-1:0]        top,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    PC_INC = 2'b00,
    PC_RET = 2'b01,
    PC_JMP = 2'b10,
    PC_BR  = 2'b11
  } pc_sel_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PC_W-1:0] pc_q,        pc_d;
  logic [CW-1:0]   count_q,     count_d;
  logic            overflow_q,  overflow_d;
  logic            underflow_q, underflow_d;

  // Stack storage is deliberately not reset: reset only discards entries by
  // clearing the pointer, which keeps the array a plain write-enabled RAM.
  logic [PC_W-1:0] stack_q [DEPTH];

  // Stack write port, computed combinationally and applied at the clock edge.
  logic            wr_en;
  logic [IW-1:0]   wr_idx;
  logic [PC_W-1:0] wr_dat;

  // ---------------------------------------------------------------------------
  // Registered-state decode (no input feeds these, so top/empty/full are
  // free of any combinational path from the controller inputs)
  // ---------------------------------------------------------------------------
  logic            empty_s;
  logic            full_s;
  logic [IW-1:0]   top_idx;
  logic [PC_W-1:0] top_s;

  assign empty_s = (count_q == '0);
  assign full_s  = (count_q == DEPTH_C);
  // When empty this wraps to DEPTH-1, but top_s masks it to zero anyway.
  assign top_idx = IW'(count_q - CW'(1));
  assign top_s   = empty_s ? '0 : stack_q[top_idx];

  // ---------------------------------------------------------------------------
  // Next-PC selection
  // ---------------------------------------------------------------------------
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_ext;
  logic [PC_W-1:0] pc_br;
  pc_sel_e         pc_sel;

  assign pc_inc = pc_q + PC_W'(1);
  // Size cast of a signed operand sign-extends; all sums wrap modulo 2^PC_W.
  assign br_ext = PC_W'($signed(br_offset));
  assign pc_br  = pc_inc + br_ext;
  assign pc_sel = pc_sel_e'(pc_state);

  always_comb begin
    pc_d = pc_q;
    if (!hold) begin
      unique case (pc_sel)
        PC_INC:  pc_d = pc_inc;
        // Return address comes from the current top whether or not pop is
        // asserted; an empty stack falls through to sequential execution.
        PC_RET:  pc_d = empty_s ? pc_inc : top_s;
        PC_JMP:  pc_d = jmp_target;
        PC_BR:   pc_d = pc_br;
        default: pc_d = pc_inc;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stack pointer, write port and sticky error flags
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wr_en       = 1'b0;
    wr_idx      = count_q[IW-1:0];
    wr_dat      = pc_inc;

    if (!hold) begin
      unique case ({push, pop})
        2'b10: begin
          if (full_s) begin
            // Dropped call: PC still moves, only the flag records it.
            overflow_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_idx  = count_q[IW-1:0];
            count_d = count_q + CW'(1);
          end
        end
        2'b01: begin
          if (empty_s) begin
            underflow_d = 1'b1;
          end else begin
            // Entry contents are left in place; only the pointer moves.
            count_d = count_q - CW'(1);
          end
        end
        2'b11: begin
          if (empty_s) begin
            // Nothing to pop: behaves as a plain push into slot 0. The stack
            // cannot be full here because DEPTH is at least 2.
            wr_en   = 1'b1;
            wr_idx  = '0;
            count_d = CW'(1);
          end else begin
            // Tail-call style replace: overwrite the top, pointer unchanged.
            wr_en  = 1'b1;
            wr_idx = top_idx;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Reset blocks the write so a same-cycle push cannot leave a stale entry
  // behind, but it never clears existing contents.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      stack_q[wr_idx] <= wr_dat;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pc        = pc_q;
  assign top       = top_s;
  assign count     = count_q;
  assign empty     = empty_s;
  assign full      = full_s;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed and randomized checks of pc_stack_unit against a queue-based
// reference model; every step compares all outputs one clock after the edge.
module tb_pc_stack_unit;

  localparam int PC_W  = 12;
  localparam int DEPTH = 8;
  localparam int MASK  = (1 << PC_W) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            hold;
  logic [1:0]      pc_state;
  logic            push;
  logic            pop;
  logic [PC_W-1:0] jmp_target;
  logic [7:0]      br_offset;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] top;
  logic [3:0]      count;
  logic            empty;
  logic            full;
  logic            overflow;
  logic            underflow;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int m_pc  = 0;
  int m_q[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  pc_stack_unit #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .pc_state   (pc_state),
    .push       (push),
    .pop        (pop),
    .jmp_target (jmp_target),
    .br_offset  (br_offset),
    .pc         (pc),
    .top        (top),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_top();
    return (m_q.size() == 0) ? 0 : m_q[m_q.size()-1];
  endfunction

  task automatic model_update(input bit r, input bit h, input int ps, input bit pu,
                              input bit po, input int tgt, input int off);
    int inc;
    int npc;
    int off_s;
    if (r) begin
      m_pc = 0;
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (!h) begin
      inc   = (m_pc + 1) & MASK;
      off_s = (off > 127) ? off - 256 : off;
      case (ps)
        0:       npc = inc;
        1:       npc = (m_q.size() != 0) ? m_q[m_q.size()-1] : inc;
        2:       npc = tgt & MASK;
        default: npc = (inc + off_s) & MASK;
      endcase
      if (pu && po) begin
        if (m_q.size() == 0) m_q.push_back(inc);
        else m_q[m_q.size()-1] = inc;
      end else if (pu) begin
        if (m_q.size() == DEPTH) m_ovf = 1'b1;
        else m_q.push_back(inc);
      end else if (po) begin
        if (m_q.size() == 0) m_unf = 1'b1;
        else void'(m_q.pop_back());
      end
      m_pc = npc;
    end
  endtask

  task automatic check_all();
    chk("pc",        32'(pc),        32'(m_pc));
    chk("top",       32'(top),       32'(m_top()));
    chk("count",     32'(count),     32'(m_q.size()));
    chk("empty",     32'(empty),     32'(m_q.size() == 0));
    chk("full",      32'(full),      32'(m_q.size() == DEPTH));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask

  task automatic step(input bit r, input bit h, input int ps, input bit pu,
                      input bit po, input int tgt, input int off);
    rst        = r;
    hold       = h;
    pc_state   = 2'(ps);
    push       = pu;
    pop        = po;
    jmp_target = PC_W'(tgt);
    br_offset  = 8'(off);
    @(posedge clk);
    model_update(r, h, ps, pu, po, tgt, off);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b0; hold = 1'b0; pc_state = 2'b00; push = 1'b0; pop = 1'b0;
    jmp_target = '0; br_offset = '0;

    // Reset, then five sequential increments
    step(1, 0, 0, 0, 0, 0, 0);
    chk("reset_pc", 32'(pc), 32'h0);
    chk("reset_top", 32'(top), 32'h0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0);
    chk("inc5_pc", 32'(pc), 32'h5);
    chk("inc5_empty", 32'(empty), 32'h1);

    // JSB to 0x200 from 0x010, then RET
    step(0, 0, 2, 0, 0, 'h010, 0);
    step(0, 0, 2, 1, 0, 'h200, 0);
    chk("jsb_pc", 32'(pc), 32'h200);
    chk("jsb_top", 32'(top), 32'h011);
    chk("jsb_count", 32'(count), 32'h1);
    step(0, 0, 1, 0, 1, 0, 0);
    chk("ret_pc", 32'(pc), 32'h011);
    chk("ret_count", 32'(count), 32'h0);

    // Negative branch to zero, and increment wrap at the top of the space
    step(0, 0, 2, 0, 0, 'h005, 0);
    step(0, 0, 3, 0, 0, 0, 'hFA);
    chk("br_neg_pc", 32'(pc), 32'h000);
    step(0, 0, 2, 0, 0, 'hFFF, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("wrap_pc", 32'(pc), 32'h000);

    // Nine nested JSBs into an eight-deep stack, then unwind past empty
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 2, 1, 0, 'h100 + i * 'h10, 0);
    chk("deep_count", 32'(count), 32'h8);
    chk("deep_full", 32'(full), 32'h1);
    chk("deep_ovf", 32'(overflow), 32'h1);
    chk("deep_top", 32'(top), 32'h161);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 1, 0, 0);
    chk("unwind_pc", 32'(pc), 32'h001);
    step(0, 0, 1, 0, 1, 0, 0);
    chk("unf_pc", 32'(pc), 32'h002);
    chk("unf_flag", 32'(underflow), 32'h1);

    // Hold overrides a pending JSB for three cycles, then it happens once
    for (int i = 0; i < 3; i++) step(0, 1, 2, 1, 0, 'h300, 0);
    chk("hold_pc", 32'(pc), 32'h002);
    step(0, 0, 2, 1, 0, 'h300, 0);
    chk("release_pc", 32'(pc), 32'h300);
    chk("release_top", 32'(top), 32'h003);
    chk("release_count", 32'(count), 32'h1);

    // Simultaneous push+pop at depth 3, then reset beating a push
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 2, 1, 0, 'h020 + i, 0);
    step(0, 0, 2, 0, 0, 'h040, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    chk("pp_count", 32'(count), 32'h3);
    chk("pp_top", 32'(top), 32'h041);
    step(1, 1, 2, 1, 0, 'h555, 0);
    chk("rst_pri_pc", 32'(pc), 32'h0);
    chk("rst_pri_count", 32'(count), 32'h0);
    step(0, 0, 1, 0, 1, 0, 0);
    chk("post_rst_ret_pc", 32'(pc), 32'h1);
    chk("post_rst_unf", 32'(underflow), 32'h1);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 4) == 0,
           int'($urandom_range(0, 3)),
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0,
           int'($urandom_range(0, MASK)),
           int'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
